// File: rtl/bram_stream_pkg.sv
// bram_stream_pkg
//   Shared types, geometry constants and helpers for the BRAM line streamer.
//   The RAM geometry (128-bit lines, 8 lines, 13-bit byte address) and the
//   32-bit stream beat width are fixed here so every file agrees on them.
//   Exports:
//     DW, WL, AW, SW     line width, depth, byte-address width, beat width
//     BEATS, IW, BW      beats per line, line-index width, beat-index width
//     state_t            main streamer FSM states
//     pf_state_t         prefetch slot states (used when BRAM_STREAM_PREFETCH_EN)
//     line_addr()        line index -> RAM byte address
package bram_stream_pkg;

  localparam int DW    = 128;
  localparam int WL    = 8;
  localparam int AW    = 13;
  localparam int SW    = 32;
  localparam int BEATS = DW / SW;
  localparam int IW    = $clog2(WL);
  localparam int BW    = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, STREAM, DONE} state_t;

  typedef enum logic [1:0] {PF_IDLE, PF_REQ, PF_WAIT, PF_FULL} pf_state_t;

  // The RAM is addressed in 32-bit words, so a line index sits above two
  // zero byte-offset bits.
  function automatic logic [AW-1:0] line_addr(input logic [IW-1:0] idx);
    return AW'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/line_unpacker.sv
// line_unpacker
//   Holds one RAM line and presents it as BEATS stream words, least
//   significant word first. A load restarts at beat 0 and takes priority
//   over an advance in the same cycle, so the next line can be loaded on the
//   handshake of the current line's last beat.
//   Ports:
//     CLK        in   clock
//     RSTN       in   asynchronous active-low reset
//     load       in   capture load_data and restart at beat 0
//     load_data  in   DW-bit line
//     advance    in   current beat accepted downstream
//     data       out  current SW-bit beat
//     last_beat  out  current beat is the final beat of the line
module line_unpacker
  import bram_stream_pkg::*;
(
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          advance,
  output logic [SW-1:0] data,
  output logic          last_beat
);

  logic [DW-1:0] line_reg;
  logic [BW-1:0] beat_reg;
  logic [SW-1:0] beat_words [BEATS];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_words[gi] = line_reg[SW*gi +: SW];
    end
  endgenerate

  // Data is a pure function of registers, so it stays put while stalled.
  assign data      = beat_words[beat_reg];
  assign last_beat = (beat_reg == BW'(BEATS - 1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      line_reg <= '0;
      beat_reg <= '0;
    end else if (load) begin
      line_reg <= load_data;
      beat_reg <= '0;
    end else if (advance) begin
      beat_reg <= last_beat ? '0 : beat_reg + 1'b1;
    end
  end

endmodule

// File: rtl/bram_line_streamer.sv
// bram_line_streamer
//   Reads a run of lines from the 128-bit x 8-line BRAM and streams each
//   line as 32-bit AXI-Stream beats, LSW first. Line indices wrap modulo the
//   RAM depth; run lengths above the depth saturate to the depth.
//   Optional feature macro: BRAM_STREAM_PREFETCH_EN
//     undefined: one line buffer, 2-cycle bubble between lines.
//     defined:   the next line is read into a second register while the
//                current one streams, giving one beat per cycle across lines.
//   Ports:
//     CLK, RSTN          clock, asynchronous active-low reset
//     start              1-cycle command, sampled only while idle
//     base_idx           first line index (captured on start)
//     num_lines          line count 0..WL, larger values saturate
//     busy, done         run in progress / 1-cycle end-of-run pulse
//     ram_EN, ram_WE,
//     ram_A, ram_Do      RAM read port (WE tied low)
//     m_tdata, m_tvalid,
//     m_tready, m_tlast  stream master
module bram_line_streamer
  import bram_stream_pkg::*;
(
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          start,
  input  logic [IW-1:0] base_idx,
  input  logic [3:0]    num_lines,
  output logic          busy,
  output logic          done,
  output logic          ram_EN,
  output logic [3:0]    ram_WE,
  output logic [AW-1:0] ram_A,
  input  logic [DW-1:0] ram_Do,
  output logic [SW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast
);

  localparam logic [IW:0] ONE_LINE = (IW+1)'(1);

  state_t        state_reg;
  logic [IW-1:0] idx_reg;
  logic [IW:0]   remaining_reg;   // lines still to finish, including the current one
  logic [IW:0]   num_sat;
  logic          handshake;
  logic          up_load;
  logic [DW-1:0] up_load_data;
  logic          up_last_beat;

  assign ram_WE    = 4'b0000;
  assign handshake = m_tvalid && m_tready;
  assign num_sat   = (int'(num_lines) > WL) ? (IW+1)'(WL) : (IW+1)'(num_lines);
  assign m_tlast   = m_tvalid && up_last_beat && (remaining_reg == ONE_LINE);

`ifdef BRAM_STREAM_PREFETCH_EN
  localparam logic [IW:0] TWO_LINES = (IW+1)'(2);

  pf_state_t     pf_state_reg;
  logic [DW-1:0] pf_line_reg;
  logic          pf_swap;

  // The prefetch for line n+1 is issued as line n starts streaming and
  // lands two cycles later, which is before beat BEATS-1 can handshake
  // whenever BEATS >= 3.
  assign pf_swap      = (state_reg == STREAM) && handshake && up_last_beat &&
                        (remaining_reg != ONE_LINE);
  assign up_load      = (state_reg == RD_WAIT) || pf_swap;
  assign up_load_data = (state_reg == RD_WAIT) ? ram_Do : pf_line_reg;
`else
  assign up_load      = (state_reg == RD_WAIT);
  assign up_load_data = ram_Do;
`endif

  line_unpacker u_unpacker (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .load      (up_load),
    .load_data (up_load_data),
    .advance   (handshake),
    .data      (m_tdata),
    .last_beat (up_last_beat)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      remaining_reg <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ram_EN        <= 1'b0;
      ram_A         <= '0;
      m_tvalid      <= 1'b0;
`ifdef BRAM_STREAM_PREFETCH_EN
      pf_state_reg  <= PF_IDLE;
      pf_line_reg   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy          <= 1'b1;
            idx_reg       <= base_idx;
            remaining_reg <= num_sat;
            if (num_sat == '0) begin
              state_reg <= DONE;
            end else begin
              state_reg <= RD_REQ;
              ram_EN    <= 1'b1;
              ram_A     <= line_addr(base_idx);
            end
          end
        end
        RD_REQ: state_reg <= RD_WAIT;
        RD_WAIT: begin
          // EN stays high through this cycle: the RAM gates Do with the live EN.
          state_reg <= STREAM;
          m_tvalid  <= 1'b1;
          ram_EN    <= 1'b0;
`ifdef BRAM_STREAM_PREFETCH_EN
          if (remaining_reg > ONE_LINE) begin
            ram_EN       <= 1'b1;
            ram_A        <= line_addr(idx_reg + 1'b1);
            pf_state_reg <= PF_REQ;
          end
`endif
        end
        STREAM: begin
`ifdef BRAM_STREAM_PREFETCH_EN
          case (pf_state_reg)
            PF_REQ:  pf_state_reg <= PF_WAIT;
            PF_WAIT: begin
              pf_line_reg  <= ram_Do;
              ram_EN       <= 1'b0;
              pf_state_reg <= PF_FULL;
            end
            default: ;
          endcase
`endif
          if (handshake && up_last_beat) begin
            remaining_reg <= remaining_reg - 1'b1;
            idx_reg       <= idx_reg + 1'b1;
            if (remaining_reg == ONE_LINE) begin
              m_tvalid  <= 1'b0;
              state_reg <= DONE;
            end else begin
`ifdef BRAM_STREAM_PREFETCH_EN
              // The unpacker takes the prefetched line this cycle; only
              // fetch again if a line remains beyond the one just swapped in.
              pf_state_reg <= PF_IDLE;
              if (remaining_reg > TWO_LINES) begin
                ram_EN       <= 1'b1;
                ram_A        <= line_addr(idx_reg + IW'(2));
                pf_state_reg <= PF_REQ;
              end
`else
              m_tvalid  <= 1'b0;
              ram_EN    <= 1'b1;
              ram_A     <= line_addr(idx_reg + 1'b1);
              state_reg <= RD_REQ;
`endif
            end
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_line_streamer.sv
module tb_bram_line_streamer;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   base_idx = '0;
  logic [3:0]   num_lines = '0;
  logic         busy, done, ram_EN;
  logic [3:0]   ram_WE;
  logic [12:0]  ram_A;
  logic [127:0] ram_Do;
  logic [31:0]  m_tdata;
  logic         m_tvalid, m_tlast;
  logic         m_tready = 1'b1;

  logic [127:0] mem [8];
  logic [127:0] ram_q = '0;

  int checks_total  = 0;
  int checks_passed = 0;

  // Scoreboard and per-run observations
  logic [31:0] exp_data [$];
  bit          exp_last [$];
  logic [12:0] addr_log [$];
  int first_valid_k, done_k, last_k, beats_taken;
  int gap_cycles, gap_runs, en_cycles, valid_cycles;

  always #5 CLK = ~CLK;

  // Behavioural BRAM: registered read, output gated by the live EN.
  always @(posedge CLK) if (ram_EN) ram_q <= mem[ram_A[4:2]];
  assign ram_Do = ram_EN ? ram_q : '0;

  bram_line_streamer dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .start     (start),
    .base_idx  (base_idx),
    .num_lines (num_lines),
    .busy      (busy),
    .done      (done),
    .ram_EN    (ram_EN),
    .ram_WE    (ram_WE),
    .ram_A     (ram_A),
    .ram_Do    (ram_Do),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast)
  );

  // Issue one start, push expected beats, then watch the stream until done,
  // a cycle budget, or stop_after accepted beats (0 = run to completion).
  task automatic run_stream(input string tag, input int base, input int num,
                            input int ready_pct, input int stop_after, input int budget);
    int nl, k;
    bit stalled, in_gap, last_taken, prev_en;
    logic [12:0]  prev_a;
    logic [31:0]  held_d, exp_d;
    bit           held_l, exp_l;
    logic [127:0] line;
    nl = (num > 8) ? 8 : num;
    for (int l = 0; l < nl; l++) begin
      line = mem[(base + l) % 8];
      for (int b = 0; b < 4; b++) begin
        exp_data.push_back(line[32*b +: 32]);
        exp_last.push_back((l == nl - 1) && (b == 3));
      end
    end
    first_valid_k = -1; done_k = -1; last_k = -1; beats_taken = 0;
    gap_cycles = 0; gap_runs = 0; en_cycles = 0; valid_cycles = 0;
    addr_log.delete();
    stalled = 0; in_gap = 0; last_taken = 0; prev_en = 0;
    prev_a = '0; held_d = '0; held_l = 0;
    $display("start %s base=%0d num=%0d ready=%0d%%", tag, base, num, ready_pct);
    @(negedge CLK);
    start = 1'b1; base_idx = 3'(base); num_lines = 4'(num); m_tready = 1'b1;
    k = 0;
    while (done_k < 0 && k < budget && !(stop_after > 0 && beats_taken >= stop_after)) begin
      @(negedge CLK);
      k++;
      start = 1'b0;
      m_tready = ($urandom_range(99) < ready_pct);
      if (k == 1) begin
        checks_total++;
        if (busy === 1'b1) checks_passed++;
        else $display("FAIL %s busy_after_start got=%b want=1", tag, busy);
      end
      if (ram_EN) begin
        en_cycles++;
        if (!prev_en || ram_A !== prev_a) addr_log.push_back(ram_A);
      end
      prev_en = ram_EN; prev_a = ram_A;
      if (stalled) begin
        checks_total++;
        if (m_tvalid === 1'b1 && m_tdata === held_d && m_tlast === held_l) checks_passed++;
        else $display("FAIL %s stall_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                      tag, m_tvalid, m_tdata, m_tlast, held_d, held_l);
      end
      if (m_tvalid) begin
        valid_cycles++;
        if (first_valid_k < 0) first_valid_k = k;
      end
      if (first_valid_k >= 0 && !last_taken && !m_tvalid) begin
        gap_cycles++;
        if (!in_gap) gap_runs++;
        in_gap = 1;
      end else begin
        in_gap = 0;
      end
      if (m_tvalid && m_tready) begin
        checks_total++;
        if (exp_data.size() == 0) begin
          $display("FAIL %s extra_beat got d=%h want no beat", tag, m_tdata);
        end else begin
          exp_d = exp_data.pop_front();
          exp_l = exp_last.pop_front();
          if (m_tdata === exp_d && m_tlast === exp_l) checks_passed++;
          else $display("FAIL %s beat%0d got d=%h l=%b want d=%h l=%b",
                        tag, beats_taken, m_tdata, m_tlast, exp_d, exp_l);
          $display("beat %s #%0d d=%h last=%b cyc=%0d", tag, beats_taken, m_tdata, m_tlast, k);
        end
        beats_taken++;
        if (m_tlast) begin
          last_taken = 1;
          last_k = k;
        end
      end
      stalled = m_tvalid && !m_tready;
      held_d = m_tdata; held_l = m_tlast;
      if (done) done_k = k;
    end
    m_tready = 1'b1;
    if (stop_after == 0) begin
      checks_total++;
      if (done_k >= 0) checks_passed++;
      else $display("FAIL %s timeout got no done within %0d cycles want done", tag, budget);
      if (done_k >= 0) begin
        @(negedge CLK);
        checks_total++;
        if (done === 1'b0 && busy === 1'b0 && m_tvalid === 1'b0 && exp_data.size() == 0)
          checks_passed++;
        else $display("FAIL %s after_done got done=%b busy=%b v=%b left=%0d want 0 0 0 0",
                      tag, done, busy, m_tvalid, exp_data.size());
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks_total++;
    if (busy === 0 && done === 0 && ram_EN === 0 && ram_A === 0 && m_tvalid === 0 &&
        m_tlast === 0 && m_tdata === 0 && ram_WE === 0) checks_passed++;
    else $display("FAIL reset_values got busy=%b done=%b en=%b a=%h v=%b l=%b d=%h we=%b want all 0",
                  busy, done, ram_EN, ram_A, m_tvalid, m_tlast, m_tdata, ram_WE);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    checks_total++;
    if (busy === 0 && m_tvalid === 0 && ram_EN === 0) checks_passed++;
    else $display("FAIL idle_after_release got busy=%b v=%b en=%b want 0 0 0", busy, m_tvalid, ram_EN);
  endtask

  task automatic test_basic();
    run_stream("basic", 0, 2, 100, 0, 100);
    checks_total++;
    if (first_valid_k === 3) checks_passed++;
    else $display("FAIL basic_latency got=%0d want=3", first_valid_k);
    checks_total++;
    if (beats_taken === 8 && done_k === last_k + 2) checks_passed++;
    else $display("FAIL basic_count_done got beats=%0d done_cyc=%0d want beats=8 done_cyc=%0d",
                  beats_taken, done_k, last_k + 2);
    checks_total++;
`ifdef BRAM_STREAM_PREFETCH_EN
    if (gap_runs === 0 && gap_cycles === 0) checks_passed++;
    else $display("FAIL basic_gaps got runs=%0d cycles=%0d want 0 0", gap_runs, gap_cycles);
`else
    if (gap_runs === 1 && gap_cycles === 2) checks_passed++;
    else $display("FAIL basic_gaps got runs=%0d cycles=%0d want 1 2", gap_runs, gap_cycles);
`endif
  endtask

  task automatic test_wrap();
    run_stream("wrap", 6, 4, 100, 0, 100);
    checks_total++;
    if (addr_log.size() == 4 && addr_log[0] === 13'h18 && addr_log[1] === 13'h1C &&
        addr_log[2] === 13'h00 && addr_log[3] === 13'h04) checks_passed++;
    else $display("FAIL wrap_addrs got n=%0d first=%h want 18 1c 00 04",
                  addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 13'h1FFF);
    checks_total++;
    if (beats_taken === 16) checks_passed++;
    else $display("FAIL wrap_beats got=%0d want=16", beats_taken);
  endtask

  task automatic test_backpressure();
    run_stream("backpressure", 2, 3, 50, 0, 400);
    checks_total++;
    if (beats_taken === 12) checks_passed++;
    else $display("FAIL backpressure_beats got=%0d want=12", beats_taken);
  endtask

  task automatic test_edge_counts();
    run_stream("num0", 4, 0, 100, 0, 20);
    checks_total++;
    if (done_k === 2 && en_cycles === 0 && valid_cycles === 0) checks_passed++;
    else $display("FAIL num0 got done_cyc=%0d en=%0d valid=%0d want 2 0 0", done_k, en_cycles, valid_cycles);
    run_stream("num12", 5, 12, 100, 0, 200);
    checks_total++;
    if (beats_taken === 32 && addr_log.size() == 8) checks_passed++;
    else $display("FAIL num12 got beats=%0d reads=%0d want 32 8", beats_taken, addr_log.size());
  endtask

  task automatic test_reset_midrun();
    run_stream("midrun", 1, 4, 100, 5, 100);
    checks_total++;
    if (beats_taken === 5) checks_passed++;
    else $display("FAIL midrun_beats got=%0d want=5", beats_taken);
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    checks_total++;
    if (busy === 0 && done === 0 && ram_EN === 0 && ram_A === 0 && m_tvalid === 0 &&
        m_tlast === 0 && m_tdata === 0) checks_passed++;
    else $display("FAIL midrun_reset got busy=%b en=%b a=%h v=%b l=%b d=%h want all 0",
                  busy, ram_EN, ram_A, m_tvalid, m_tlast, m_tdata);
    exp_data.delete();
    exp_last.delete();
    @(negedge CLK);
    RSTN = 1'b1;
    run_stream("after_reset", 1, 4, 100, 0, 100);
    checks_total++;
    if (beats_taken === 16 && first_valid_k === 3) checks_passed++;
    else $display("FAIL after_reset got beats=%0d lat=%0d want 16 3", beats_taken, first_valid_k);
  endtask

  task automatic test_back_to_back();
    run_stream("rate", 0, 3, 100, 0, 100);
    checks_total++;
`ifdef BRAM_STREAM_PREFETCH_EN
    if (gap_runs === 0 && valid_cycles === 12) checks_passed++;
    else $display("FAIL rate_gaps got runs=%0d valid=%0d want 0 12", gap_runs, valid_cycles);
`else
    if (gap_runs === 2 && gap_cycles === 4 && valid_cycles === 12) checks_passed++;
    else $display("FAIL rate_gaps got runs=%0d cycles=%0d valid=%0d want 2 4 12",
                  gap_runs, gap_cycles, valid_cycles);
`endif
  endtask

  initial begin
    logic [127:0] line;
    for (int l = 0; l < 8; l++) begin
      for (int b = 0; b < 4; b++) line[32*b +: 32] = $urandom;
      mem[l] = line;
    end
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < 4; b++) line[32*b +: 32] = 32'hA000_0000 | (32'(l) << 8) | 32'(b);
      mem[l] = line;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edge_counts();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
